// File: rtl/axis_insert_pkg.sv
// rtl/axis_insert_pkg.sv - shared types and helpers for the insert-path arbiters
package axis_insert_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Index width for a channel count; a single channel still needs one bit
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_insert_arbiter_if.sv
// rtl/axis_insert_arbiter_if.sv - requester-side and inserter-side streams of the insert arbiter
interface axis_insert_arbiter_if #(
    parameter int NUM_CH       = 4,
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8
);
    logic [NUM_CH-1:0]              s_hdr_tvalid;
    logic [NUM_CH*DATA_WD-1:0]      s_hdr_tdata;
    logic [NUM_CH*DATA_BYTE_WD-1:0] s_hdr_tkeep;
    logic [NUM_CH-1:0]              s_hdr_tready;
    logic [NUM_CH-1:0]              s_dat_tvalid;
    logic [NUM_CH*DATA_WD-1:0]      s_dat_tdata;
    logic [NUM_CH*DATA_BYTE_WD-1:0] s_dat_tkeep;
    logic [NUM_CH-1:0]              s_dat_tlast;
    logic [NUM_CH-1:0]              s_dat_tready;

    logic                    m_hdr_tvalid;
    logic [DATA_WD-1:0]      m_hdr_tdata;
    logic [DATA_BYTE_WD-1:0] m_hdr_tkeep;
    logic                    m_hdr_tready;
    logic                    m_dat_tvalid;
    logic [DATA_WD-1:0]      m_dat_tdata;
    logic [DATA_BYTE_WD-1:0] m_dat_tkeep;
    logic                    m_dat_tlast;
    logic                    m_dat_tready;

    // Arbiter view: consumes the requester streams, drives the inserter streams
    modport master (
        input  s_hdr_tvalid, s_hdr_tdata, s_hdr_tkeep,
        output s_hdr_tready,
        input  s_dat_tvalid, s_dat_tdata, s_dat_tkeep, s_dat_tlast,
        output s_dat_tready,
        output m_hdr_tvalid, m_hdr_tdata, m_hdr_tkeep,
        input  m_hdr_tready,
        output m_dat_tvalid, m_dat_tdata, m_dat_tkeep, m_dat_tlast,
        input  m_dat_tready
    );

    modport slave (
        output s_hdr_tvalid, s_hdr_tdata, s_hdr_tkeep,
        input  s_hdr_tready,
        output s_dat_tvalid, s_dat_tdata, s_dat_tkeep, s_dat_tlast,
        input  s_dat_tready,
        input  m_hdr_tvalid, m_hdr_tdata, m_hdr_tkeep,
        output m_hdr_tready,
        input  m_dat_tvalid, m_dat_tdata, m_dat_tkeep, m_dat_tlast,
        output m_dat_tready
    );

endinterface

// File: rtl/axis_insert_arbiter_rr_pick.sv
// rtl/axis_insert_arbiter_rr_pick.sv - combinational round-robin picker (rotate, priority-encode, un-rotate)
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int CH_WD  = 2
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_WD-1:0]  i_ptr,
    output logic              o_found,
    output logic [CH_WD-1:0]  o_idx
);

    // Both operands are below NUM_CH, so one conditional subtract is a full modulo
    function automatic logic [CH_WD-1:0] wrap_add(input logic [CH_WD-1:0] a,
                                                  input logic [CH_WD-1:0] b);
        logic [CH_WD:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (CH_WD+1)'(NUM_CH)) s = s - (CH_WD+1)'(NUM_CH);
        return s[CH_WD-1:0];
    endfunction

    logic [NUM_CH-1:0] w_rot;
    logic [CH_WD-1:0]  w_off;

    always_comb begin
        w_rot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_rot[k] = i_req[wrap_add(i_ptr, CH_WD'(k))];
        end
    end

    always_comb begin
        w_off = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = CH_WD'(k);
        end
    end

    assign o_found = |w_rot;
    assign o_idx   = wrap_add(i_ptr, w_off);

endmodule

// File: rtl/axis_insert_arbiter.sv
// rtl/axis_insert_arbiter.sv - packet-locked round-robin arbiter in front of the header inserter
module axis_insert_arbiter
    import axis_insert_pkg::*;
#(
    parameter int  NUM_CH       = 4,
    parameter int  DATA_WD      = 32,
    parameter int  DATA_BYTE_WD = DATA_WD / 8,
    localparam int CH_WD        = ch_width(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axis_insert_arbiter_if.master bus,
    output logic [CH_WD-1:0]      grant_o,
    output logic                  busy_o
);

    arb_state_e       r_state;
    logic [CH_WD-1:0] r_grant;
    logic [CH_WD-1:0] r_rr_ptr;
    logic             r_hdr_sent;

    logic [DATA_WD-1:0]      w_hdr_data [NUM_CH];
    logic [DATA_BYTE_WD-1:0] w_hdr_keep [NUM_CH];
    logic [DATA_WD-1:0]      w_dat_data [NUM_CH];
    logic [DATA_BYTE_WD-1:0] w_dat_keep [NUM_CH];

    logic             w_busy;
    logic             w_found;
    logic [CH_WD-1:0] w_pick;
    logic [CH_WD-1:0] w_next_ptr;
    logic             w_hdr_hs;
    logic             w_dat_hs;
    logic             w_release;
    logic [NUM_CH-1:0] w_hdr_rdy;
    logic [NUM_CH-1:0] w_dat_rdy;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign w_hdr_data[i] = bus.s_hdr_tdata[i*DATA_WD +: DATA_WD];
        assign w_hdr_keep[i] = bus.s_hdr_tkeep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        assign w_dat_data[i] = bus.s_dat_tdata[i*DATA_WD +: DATA_WD];
        assign w_dat_keep[i] = bus.s_dat_tkeep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
    end

    rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_WD  (CH_WD)
    ) u_rr_pick (
        .i_req   (bus.s_hdr_tvalid),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign w_busy = (r_state == ST_BUSY);

    // Payload fields follow the grant even in IDLE; only valid/ready are gated
    assign bus.m_hdr_tvalid = w_busy & bus.s_hdr_tvalid[r_grant] & ~r_hdr_sent;
    assign bus.m_hdr_tdata  = w_hdr_data[r_grant];
    assign bus.m_hdr_tkeep  = w_hdr_keep[r_grant];
    assign bus.m_dat_tvalid = w_busy & bus.s_dat_tvalid[r_grant];
    assign bus.m_dat_tdata  = w_dat_data[r_grant];
    assign bus.m_dat_tkeep  = w_dat_keep[r_grant];
    assign bus.m_dat_tlast  = bus.s_dat_tlast[r_grant];

    always_comb begin
        w_hdr_rdy = '0;
        w_dat_rdy = '0;
        if (w_busy) begin
            w_hdr_rdy[r_grant] = bus.m_hdr_tready & ~r_hdr_sent;
            w_dat_rdy[r_grant] = bus.m_dat_tready;
        end
    end

    assign bus.s_hdr_tready = w_hdr_rdy;
    assign bus.s_dat_tready = w_dat_rdy;

    assign w_hdr_hs   = bus.m_hdr_tvalid & bus.m_hdr_tready;
    assign w_dat_hs   = bus.m_dat_tvalid & bus.m_dat_tready;
    // A last beat only closes the packet once its header has gone (or goes now)
    assign w_release  = w_dat_hs & bus.m_dat_tlast & (r_hdr_sent | w_hdr_hs);
    assign w_next_ptr = (r_grant == CH_WD'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_hdr_sent <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant    <= w_pick;
                        r_hdr_sent <= 1'b0;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_hdr_hs) r_hdr_sent <= 1'b1;
                    if (w_release) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant_o = r_grant;
    assign busy_o  = w_busy;

endmodule

// File: tb/tb_axis_insert_arbiter.sv
// tb/tb_axis_insert_arbiter.sv - directed self-checking bench for axis_insert_arbiter
module tb_axis_insert_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int KW  = DW / 8;

    logic       clk;
    logic       rst_n;
    logic [1:0] grant_o;
    logic       busy_o;

    int n_total;
    int n_bad;

    // Requester model: packets pending, current beat, packet length per channel
    int         pend  [NCH];
    int         beat  [NCH];
    int         nbeat [NCH];
    logic [3:0] hdr_done;
    logic [3:0] hold_hdr;
    logic       dat_rdy;

    axis_insert_arbiter_if #(.NUM_CH(NCH), .DATA_WD(DW)) bus ();

    axis_insert_arbiter #(
        .NUM_CH  (NCH),
        .DATA_WD (DW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .grant_o (grant_o),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_hdr(input int ch);
        return 32'h4800_0000 | 32'(ch);
    endfunction

    function automatic logic [31:0] mk_dat(input int ch, input int b);
        return 32'hDA00_0000 | (32'(ch) << 8) | 32'(b);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NCH; i++) begin
            pend[i]  = 0;
            beat[i]  = 0;
            nbeat[i] = 1;
        end
        hdr_done = '0;
        hold_hdr = '0;
        dat_rdy  = 1'b1;
    endtask

    task automatic drive();
        for (int i = 0; i < NCH; i++) begin
            bus.s_hdr_tvalid[i]           = hold_hdr[i] | (pend[i] > 0 && !hdr_done[i]);
            bus.s_hdr_tdata[i*DW +: DW]   = mk_hdr(i);
            bus.s_hdr_tkeep[i*KW +: KW]   = 4'hF;
            bus.s_dat_tvalid[i]           = (pend[i] > 0);
            bus.s_dat_tdata[i*DW +: DW]   = mk_dat(i, beat[i]);
            bus.s_dat_tkeep[i*KW +: KW]   = 4'hF;
            bus.s_dat_tlast[i]            = (beat[i] == nbeat[i] - 1);
        end
        bus.m_hdr_tready = 1'b1;
        bus.m_dat_tready = dat_rdy;
    endtask

    // Commit the handshakes of the cycle that is about to close
    task automatic advance();
        for (int i = 0; i < NCH; i++) begin
            if (bus.s_hdr_tvalid[i] && bus.s_hdr_tready[i]) hdr_done[i] = 1'b1;
            if (bus.s_dat_tvalid[i] && bus.s_dat_tready[i]) begin
                if (bus.s_dat_tlast[i]) begin
                    beat[i]     = 0;
                    hdr_done[i] = 1'b0;
                    pend[i]     = pend[i] - 1;
                end else begin
                    beat[i] = beat[i] + 1;
                end
            end
        end
    endtask

    task automatic tick();
        advance();
        @(negedge clk);
        drive();
        #1;
    endtask

    initial begin
        int order [5];
        int exp_bd [8];
        int exp_hr [8];
        int k;
        int ph;

        n_total = 0;
        n_bad   = 0;
        order   = '{0, 1, 2, 3, 0};
        exp_bd  = '{1, 1, 1, 0, 1, 1, 1, 0};
        exp_hr  = '{1, 0, 0, 0, 1, 0, 0, 0};

        // Reset with every channel requesting
        rst_n = 1'b0;
        clear_model();
        for (int i = 0; i < NCH; i++) begin
            pend[i]  = 1;
            nbeat[i] = 2;
        end
        pend[0] = 2;
        tick();
        tick();
        check("rst_s_hdr_tready", 32'(bus.s_hdr_tready), 0);
        check("rst_s_dat_tready", 32'(bus.s_dat_tready), 0);
        check("rst_m_hdr_tvalid", 32'(bus.m_hdr_tvalid), 0);
        check("rst_m_dat_tvalid", 32'(bus.m_dat_tvalid), 0);
        check("rst_grant", 32'(grant_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        rst_n = 1'b1;

        // Fairness: 2-beat packets, busy 2 cycles then one idle cycle each
        for (int t = 1; t <= 15; t++) begin
            tick();
            check("fair_busy", 32'(busy_o), 32'((t % 3) != 0));
            if ((t % 3) != 0) begin
                k  = (t - 1) / 3;
                ph = (t - 1) % 3;
                check("fair_grant", 32'(grant_o), 32'(order[k]));
                check("fair_hdr_valid", 32'(bus.m_hdr_tvalid), 32'(ph == 0));
                check("fair_dat_data", bus.m_dat_tdata, mk_dat(order[k], ph));
                check("fair_dat_last", 32'(bus.m_dat_tlast), 32'(ph == 1));
            end
        end

        // Duplicate header held by channel 0 across two 3-beat packets
        nbeat[0]    = 3;
        pend[0]     = 2;
        hold_hdr[0] = 1'b1;
        tick();
        for (int t = 1; t <= 8; t++) begin
            tick();
            check("dup_busy", 32'(busy_o), 32'(exp_bd[t-1]));
            check("dup_hdr_ready0", 32'(bus.s_hdr_tready[0]), 32'(exp_hr[t-1]));
            if (exp_bd[t-1] != 0) check("dup_grant", 32'(grant_o), 0);
            if (t == 5) hold_hdr[0] = 1'b0;
        end

        // Backpressure on a 5-beat packet from channel 2, channel 3 waiting
        nbeat[2] = 5;
        pend[2]  = 1;
        nbeat[3] = 1;
        pend[3]  = 1;
        dat_rdy  = 1'b1;
        tick();
        for (int t = 1; t <= 12; t++) begin
            dat_rdy = (t >= 10) ? 1'b1 : 1'(t % 2);
            tick();
            if (t <= 9) begin
                check("bp_busy", 32'(busy_o), 1);
                check("bp_grant", 32'(grant_o), 2);
                check("bp_ch3_hdr_ready", 32'(bus.s_hdr_tready[3]), 0);
                if ((t % 2) == 1) begin
                    check("bp_dat_data", bus.m_dat_tdata, mk_dat(2, (t - 1) / 2));
                    check("bp_dat_last", 32'(bus.m_dat_tlast), 32'(t == 9));
                end
            end else if (t == 11) begin
                check("bp_ch3_busy", 32'(busy_o), 1);
                check("bp_ch3_grant", 32'(grant_o), 3);
            end else begin
                check("bp_gap", 32'(busy_o), 0);
            end
        end

        // Single-beat packet on channel 1: header and last in one cycle
        nbeat[1] = 1;
        pend[1]  = 1;
        tick();
        tick();
        check("sc_busy", 32'(busy_o), 1);
        check("sc_grant", 32'(grant_o), 1);
        check("sc_hdr_valid", 32'(bus.m_hdr_tvalid), 1);
        check("sc_hdr_data", bus.m_hdr_tdata, mk_hdr(1));
        check("sc_dat_last", 32'(bus.m_dat_tlast), 1);
        check("sc_hdr_ready", 32'(bus.s_hdr_tready), 32'h2);
        check("sc_dat_ready", 32'(bus.s_dat_tready), 32'h2);
        tick();
        check("sc_idle_next", 32'(busy_o), 0);
        // With rr_ptr at 2, channels 0..2 requesting must be served 2, 0, 1
        for (int i = 0; i < 3; i++) begin
            pend[i]  = 1;
            nbeat[i] = 1;
        end
        tick();
        for (int t = 4; t <= 9; t++) begin
            tick();
            check("rr_busy", 32'(busy_o), 32'((t % 2) == 0));
            if ((t % 2) == 0) check("rr_grant", 32'(grant_o), 32'(order[0] + (t == 4 ? 2 : (t == 6 ? 0 : 1))));
        end

        // Mid-packet reset during the third beat of six on channel 3
        nbeat[3] = 6;
        pend[3]  = 1;
        tick();
        for (int t = 1; t <= 3; t++) tick();
        check("mr_busy_before", 32'(busy_o), 1);
        check("mr_grant_before", 32'(grant_o), 3);
        check("mr_dat_data", bus.m_dat_tdata, mk_dat(3, 2));
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_busy_reset", 32'(busy_o), 0);
        check("mr_grant_reset", 32'(grant_o), 0);
        check("mr_dat_valid_reset", 32'(bus.m_dat_tvalid), 0);
        check("mr_dat_ready_reset", 32'(bus.s_dat_tready), 0);
        clear_model();
        pend[1]  = 1;
        nbeat[1] = 2;
        pend[3]  = 1;
        nbeat[3] = 2;
        tick();
        rst_n = 1'b1;
        tick();
        check("mr_fresh_busy", 32'(busy_o), 1);
        check("mr_fresh_grant", 32'(grant_o), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
